// File: rtl/cdc_fifo_pkg.sv
// Shared CDC FIFO definitions: default geometry and Gray-code helpers used by
// both the read-side and write-side pointer logic.
package cdc_fifo_pkg;

  localparam int ADDRESS_WIDTH_DEFAULT = 4;
  localparam int SYNC_STAGES_DEFAULT   = 2;

  // Helpers work on a fixed wide word; callers zero-extend and truncate.
  localparam int GRAY_MAX_W = 16;

  function automatic logic [GRAY_MAX_W-1:0] gray_encode(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray_decode(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Plain multi-flop synchronizer for a Gray-coded bus; stage 0 samples the
// foreign-domain input, the last stage is the safe output.
module cdc_sync_bus #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2   // legal range 2..4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [STAGES-1:0][WIDTH-1:0] sync_d;
  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Pure shift: no logic may sit between stages.
  always_comb begin
    sync_d[0] = data_in;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign data_out = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_fifo_read_state.sv
// Read-domain pointer state for an async FIFO: synchronizes the write Gray
// pointer, tracks the read pointer and derives empty / level / almost_empty.
module cdc_fifo_read_state
  import cdc_fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH      = ADDRESS_WIDTH_DEFAULT,
  parameter int SYNC_STAGES        = SYNC_STAGES_DEFAULT,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     increment,
  input  logic [ADDRESS_WIDTH-1:0] write_address_gray,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [ADDRESS_WIDTH-1:0] read_address_gray,
  output logic                     empty,
  output logic                     almost_empty,
  output logic [ADDRESS_WIDTH-1:0] level
);

  localparam int unsigned AE_LEVEL = ALMOST_EMPTY_LEVEL;

  logic [ADDRESS_WIDTH-1:0] write_sync_gray;
  logic [ADDRESS_WIDTH-1:0] write_sync;
  logic [ADDRESS_WIDTH-1:0] read_address_d,      read_address_q;
  logic [ADDRESS_WIDTH-1:0] read_address_gray_d, read_address_gray_q;
  logic                     pop;

  cdc_sync_bus #(
    .WIDTH  (ADDRESS_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_write_sync (
    .clock    (clock),
    .reset    (reset),
    .data_in  (write_address_gray),
    .data_out (write_sync_gray)
  );

  assign write_sync = ADDRESS_WIDTH'(gray_decode(GRAY_MAX_W'(write_sync_gray)));

  // Status depends only on flopped values, so it is glitch-free at the edge.
  assign empty = (read_address_q == write_sync);
  assign level = write_sync - read_address_q;
  assign almost_empty = (32'(level) <= AE_LEVEL);

  // Gray flop is loaded from the next binary value so it tracks read_address
  // exactly and moves by one bit per pop; no input reaches it combinationally.
  always_comb begin
    pop                 = increment & ~empty;
    read_address_d      = read_address_q + ADDRESS_WIDTH'(pop);
    read_address_gray_d = ADDRESS_WIDTH'(gray_encode(GRAY_MAX_W'(read_address_d)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_address_q      <= '0;
      read_address_gray_q <= '0;
    end else begin
      read_address_q      <= read_address_d;
      read_address_gray_q <= read_address_gray_d;
    end
  end

  assign read_address      = read_address_q;
  assign read_address_gray = read_address_gray_q;

endmodule

// File: tb/tb_cdc_fifo_read_state.sv
// Directed bench for cdc_fifo_read_state with a delay-line occupancy model and
// literal checks on the key scenarios.
module tb_cdc_fifo_read_state;

  localparam int AW   = 4;
  localparam int SYNC = 2;
  localparam int AEL  = 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          increment;
  logic [AW-1:0] write_address_gray;
  logic [AW-1:0] read_address;
  logic [AW-1:0] read_address_gray;
  logic          empty;
  logic          almost_empty;
  logic [AW-1:0] level;

  int vectors = 0;
  int miscompares = 0;

  cdc_fifo_read_state #(
    .ADDRESS_WIDTH      (AW),
    .SYNC_STAGES        (SYNC),
    .ALMOST_EMPTY_LEVEL (AEL)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .increment          (increment),
    .write_address_gray (write_address_gray),
    .read_address       (read_address),
    .read_address_gray  (read_address_gray),
    .empty              (empty),
    .almost_empty       (almost_empty),
    .level              (level)
  );

  always #5 clock = ~clock;

  function automatic logic [AW-1:0] to_gray(input int b);
    logic [AW-1:0] v;
    v = AW'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [AW-1:0] from_gray(input logic [AW-1:0] g);
    logic [AW-1:0] b;
    b[AW-1] = g[AW-1];
    for (int i = AW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the read side sees the write pointer as applied SYNC edges ago;
  // the read pointer advances whenever a pop is requested and data exists.
  logic [AW-1:0] m_hist [SYNC];
  int            m_rd;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC; i++) m_hist[i] <= '0;
      m_rd <= 0;
    end else begin
      m_hist[0] <= from_gray(write_address_gray);
      for (int i = 1; i < SYNC; i++) m_hist[i] <= m_hist[i-1];
      if (increment && (AW'(m_rd) != m_hist[SYNC-1])) m_rd <= (m_rd + 1) % (1 << AW);
    end
  end

  always @(negedge clock) begin
    int lvl;
    lvl = (int'(m_hist[SYNC-1]) - m_rd + (1 << AW)) % (1 << AW);
    chk("model.read_address", int'(read_address), m_rd);
    chk("model.read_address_gray", int'(read_address_gray), int'(to_gray(m_rd)));
    chk("model.level", int'(level), lvl);
    chk("model.empty", int'(empty), int'(lvl == 0));
    chk("model.almost_empty", int'(almost_empty), int'(lvl <= AEL));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int wr;
  int exp_rd [5]   = '{14, 15, 0, 1, 2};
  int exp_gray [5] = '{4'b1001, 4'b1000, 4'b0000, 4'b0001, 4'b0011};

  initial begin
    reset = 1'b1;
    increment = 1'b0;
    write_address_gray = 4'b0110;
    wr = 0;
    ticks(3);
    // Reset holds everything at zero even with a nonzero foreign pointer.
    chk("reset.read_address", int'(read_address), 0);
    chk("reset.read_address_gray", int'(read_address_gray), 0);
    chk("reset.empty", int'(empty), 1);
    chk("reset.level", int'(level), 0);
    chk("reset.almost_empty", int'(almost_empty), 1);
    write_address_gray = 4'b0000;
    tick();
    reset = 1'b0;
    ticks(3);

    // Sync latency: change after edge N, visible after edge N+2.
    wr = 1;
    write_address_gray = to_gray(wr);
    tick();
    chk("latency.empty_n1", int'(empty), 1);
    tick();
    chk("latency.empty_n2", int'(empty), 0);
    chk("latency.level_n2", int'(level), 1);

    // Pop to empty: three requests, one pop.
    increment = 1'b1;
    ticks(3);
    increment = 1'b0;
    chk("pop1.read_address", int'(read_address), 1);
    chk("pop1.read_address_gray", int'(read_address_gray), 4'b0001);
    chk("pop1.empty", int'(empty), 1);

    // Bring read pointer to 13, then write pointer to 2 across the wrap.
    while (wr != 13) begin
      wr++;
      write_address_gray = to_gray(wr);
      tick();
    end
    ticks(3);
    increment = 1'b1;
    ticks(12);
    increment = 1'b0;
    chk("setup.read_address13", int'(read_address), 13);
    while (wr != 2) begin
      wr = (wr + 1) % 16;
      write_address_gray = to_gray(wr);
      tick();
    end
    ticks(3);
    chk("wrap.level_before", int'(level), 5);
    increment = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wrap.read_address", int'(read_address), exp_rd[i]);
      chk("wrap.read_address_gray", int'(read_address_gray), exp_gray[i]);
    end
    increment = 1'b0;
    chk("wrap.empty_after", int'(empty), 1);

    // Concurrent pop and sync update at level 3.
    for (int i = 0; i < 3; i++) begin
      wr++;
      write_address_gray = to_gray(wr);
      tick();
    end
    ticks(3);
    chk("conc.level_before", int'(level), 3);
    wr++;
    write_address_gray = to_gray(wr);
    tick();
    increment = 1'b1;
    tick();
    increment = 1'b0;
    chk("conc.level_after", int'(level), 3);
    chk("conc.almost_empty", int'(almost_empty), 0);
    chk("conc.read_address", int'(read_address), 3);

    // Async reset between edges from read_address 5.
    increment = 1'b1;
    ticks(2);
    increment = 1'b0;
    chk("areset.read_address_before", int'(read_address), 5);
    #3;
    reset = 1'b1;
    #1;
    chk("areset.read_address", int'(read_address), 0);
    chk("areset.read_address_gray", int'(read_address_gray), 0);
    chk("areset.empty", int'(empty), 1);
    chk("areset.level", int'(level), 0);
    chk("areset.almost_empty", int'(almost_empty), 1);
    tick();
    reset = 1'b0;
    ticks(4);
    chk("post_reset.level", int'(level), 6);

    // Drain partially with a toggling request.
    for (int i = 0; i < 8; i++) begin
      increment = i[0];
      tick();
    end
    increment = 1'b0;
    ticks(2);
    chk("drain.read_address", int'(read_address), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
